eu_iqueue: RTL and testbench

Per-execution-unit instruction queue that sits directly upstream of the EU operand pre-population stage. It buffers decoded type_iqueue_entry words together with their operand-kind flags, presents the oldest entry as the current instruction, and retires it when the downstream stage reports a dispatch. It also provides a new-head pulse and a head-stall counter, so the pre-population register and the perf logic can track instruction boundaries.

---
 rtl/eu_iqueue.sv | 200 ++++++++++++++++++++
 tb/tb_eu_iqueue.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/eu_iqueue.sv
// ============================================================================
// eu_iqueue -- per-execution-unit instruction queue
//
// Buffers decoded type_iqueue_entry words with their operand-kind flags.
// The oldest entry is shown as the current instruction, and it retires when
// the downstream operand pre-population stage reports a dispatch. A new-head
// pulse marks instruction boundaries. A saturating head-stall counter feeds
// the perf logic.
//
// Optional feature macro: EU_IQUEUE_BYPASS_EN
//   Defined   : when the queue is empty, an incoming entry goes straight to
//               the head outputs in the same cycle. If it is dispatched in
//               that cycle, it is never written into storage.
//   Undefined : an entry reaches the head one cycle after it is pushed.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   enq_valid_i/enq_ready_o enqueue handshake
//   enq_instr_i, enq_op*_i  entry payload and operand-kind flags
//   flush_i                 discard every entry (has highest priority)
//   dispatch_i              downstream consumed the head
//   head_valid_o            head outputs hold a live entry
//   current_instr_o, op*_o  head entry and flags (zero while not valid)
//   new_head_o              first cycle a head entry is presented
//   count_o                 occupancy
//   stall_cnt_o             consecutive cycles the head waited undispatched
// ============================================================================

package eu_iqueue_pkg;
    typedef struct packed {
        logic [7:0]  opcode;
        logic [5:0]  dst;
        logic [5:0]  src0;
        logic [5:0]  src1;
        logic [15:0] imm;
    } type_iqueue_entry;

    localparam int IQ_ENTRY_W = $bits(type_iqueue_entry);
endpackage

module eu_iqueue
    import eu_iqueue_pkg::*;
#(
    parameter int EU_IDX  = 0,
    parameter int DEPTH   = 4,
    parameter int STALL_W = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enq_valid_i,
    output logic                         enq_ready_o,
    input  logic [IQ_ENTRY_W-1:0]        enq_instr_i,
    input  logic                         enq_op0_isreg_i,
    input  logic                         enq_op0_isforeign_i,
    input  logic                         enq_op1_isreg_i,
    input  logic                         enq_op1_isforeign_i,
    input  logic                         flush_i,
    input  logic                         dispatch_i,
    output logic                         head_valid_o,
    output logic [IQ_ENTRY_W-1:0]        current_instr_o,
    output logic                         op0_isreg_o,
    output logic                         op0_isforeign_o,
    output logic                         op1_isreg_o,
    output logic                         op1_isforeign_o,
    output logic                         new_head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic [STALL_W-1:0]           stall_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [IQ_ENTRY_W-1:0] instr;
        logic                  op0_isreg;
        logic                  op0_isforeign;
        logic                  op1_isreg;
        logic                  op1_isforeign;
    } slot_t;

    slot_t              mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic               new_head_q, new_head_d;

    slot_t enq_slot;
    slot_t head_slot;
    logic  stored_valid;
    logic  bypass_hit;
    logic  push;
    logic  pop;

    assign enq_slot = '{instr:         enq_instr_i,
                        op0_isreg:     enq_op0_isreg_i,
                        op0_isforeign: enq_op0_isforeign_i,
                        op1_isreg:     enq_op1_isreg_i,
                        op1_isforeign: enq_op1_isforeign_i};

    assign stored_valid = (count_q != '0);
    assign enq_ready_o  = (count_q < CNT_W'(DEPTH));

`ifdef EU_IQUEUE_BYPASS_EN
    // An empty queue exposes the incoming entry directly at the head.
    assign bypass_hit = !stored_valid && enq_valid_i && !flush_i;
`else
    assign bypass_hit = 1'b0;
`endif

    // A bypassed entry that is dispatched in the same cycle is never stored.
    assign push = enq_valid_i && enq_ready_o && !flush_i && !(bypass_hit && dispatch_i);
    // Dispatch with no stored entry is ignored. A bypassed entry never needs a pop.
    assign pop  = dispatch_i && stored_valid && !flush_i;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        head_slot = '0;
        if (bypass_hit) begin
            head_slot = enq_slot;
        end else if (stored_valid) begin
            head_slot = mem_q[rd_ptr_q];
        end
    end

    assign head_valid_o    = stored_valid || bypass_hit;
    assign current_instr_o = head_slot.instr;
    assign op0_isreg_o     = head_slot.op0_isreg;
    assign op0_isforeign_o = head_slot.op0_isforeign;
    assign op1_isreg_o     = head_slot.op1_isreg;
    assign op1_isforeign_o = head_slot.op1_isforeign;
    assign new_head_o      = new_head_q || bypass_hit;
    assign count_o         = count_q;
    assign stall_cnt_o     = stall_cnt_q;

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        stall_cnt_d = stall_cnt_q;
        new_head_d  = 1'b0;

        if (flush_i) begin
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            stall_cnt_d = '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase

            // A bypassed head was already announced combinationally, so it
            // gets no second pulse.
            new_head_d = (push && !pop && !stored_valid && !bypass_hit) ||
                         (pop && (count_d != '0));

            if (pop || !stored_valid) begin
                stall_cnt_d = '0;
            end else if (!dispatch_i && !(&stall_cnt_q)) begin
                stall_cnt_d = stall_cnt_q + STALL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            stall_cnt_q <= '0;
            new_head_q  <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            stall_cnt_q <= stall_cnt_d;
            new_head_q  <= new_head_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; count_q gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= enq_slot;
        end
    end

    a_no_dispatch_when_empty: assert property (@(posedge clk) disable iff (reset)
        !(dispatch_i && !head_valid_o && !flush_i))
        else $error("eu_iqueue[%0d]: dispatch_i asserted with no head entry", EU_IDX);

endmodule

// File: tb/tb_eu_iqueue.sv
module tb_eu_iqueue;
    import eu_iqueue_pkg::*;

    localparam int DEPTH     = 4;
    localparam int STALL_W   = 8;
    localparam int CNT_W     = $clog2(DEPTH+1);
    localparam int SLOT_W    = IQ_ENTRY_W + 4;
    localparam int STALL_MAX = (1 << STALL_W) - 1;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  enq_valid_i;
    logic                  enq_ready_o;
    logic [IQ_ENTRY_W-1:0] enq_instr_i;
    logic                  enq_op0_isreg_i, enq_op0_isforeign_i;
    logic                  enq_op1_isreg_i, enq_op1_isforeign_i;
    logic                  flush_i;
    logic                  dispatch_i;
    logic                  head_valid_o;
    logic [IQ_ENTRY_W-1:0] current_instr_o;
    logic                  op0_isreg_o, op0_isforeign_o, op1_isreg_o, op1_isforeign_o;
    logic                  new_head_o;
    logic [CNT_W-1:0]      count_o;
    logic [STALL_W-1:0]    stall_cnt_o;

    logic [SLOT_W-1:0]     slot_in;

    assign {enq_instr_i, enq_op0_isreg_i, enq_op0_isforeign_i,
            enq_op1_isreg_i, enq_op1_isforeign_i} = slot_in;

    always #5 clk = ~clk;

    eu_iqueue #(.EU_IDX(0), .DEPTH(DEPTH), .STALL_W(STALL_W)) dut (
        .clk                 (clk),
        .reset               (reset),
        .enq_valid_i         (enq_valid_i),
        .enq_ready_o         (enq_ready_o),
        .enq_instr_i         (enq_instr_i),
        .enq_op0_isreg_i     (enq_op0_isreg_i),
        .enq_op0_isforeign_i (enq_op0_isforeign_i),
        .enq_op1_isreg_i     (enq_op1_isreg_i),
        .enq_op1_isforeign_i (enq_op1_isforeign_i),
        .flush_i             (flush_i),
        .dispatch_i          (dispatch_i),
        .head_valid_o        (head_valid_o),
        .current_instr_o     (current_instr_o),
        .op0_isreg_o         (op0_isreg_o),
        .op0_isforeign_o     (op0_isforeign_o),
        .op1_isreg_o         (op1_isreg_o),
        .op1_isforeign_o     (op1_isforeign_o),
        .new_head_o          (new_head_o),
        .count_o             (count_o),
        .stall_cnt_o         (stall_cnt_o)
    );

    int tests = 0;
    int fails = 0;

    // Scoreboard: entries accepted by the model, oldest first.
    logic [SLOT_W-1:0] sb[$];
    int                exp_stall = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [SLOT_W-1:0] head_obs();
        return {current_instr_o, op0_isreg_o, op0_isforeign_o, op1_isreg_o, op1_isforeign_o};
    endfunction

    function automatic logic [SLOT_W-1:0] mk(input int n, input logic [3:0] flags);
        type_iqueue_entry e;
        e.opcode = 8'(n + 16);
        e.dst    = 6'(n);
        e.src0   = 6'(n + 1);
        e.src1   = 6'(n + 2);
        e.imm    = 16'((n * 257) ^ 16'hA5A5);
        return {e, flags};
    endfunction

    // One clock: update the model from the pre-edge inputs, then compare
    // the post-edge outputs.
    task automatic cycle();
        int size;
        bit do_push, do_pop, exp_nh;
        size = sb.size();
        check("enq_ready", 64'(enq_ready_o), 64'(size < DEPTH));
        check("head_valid", 64'(head_valid_o), 64'(size != 0));
        do_push = enq_valid_i && (size < DEPTH) && !flush_i;
        do_pop  = dispatch_i && (size != 0) && !flush_i;
        if (do_pop) begin
            check("dispatch_order", 64'(head_obs()), 64'(sb[0]));
            void'(sb.pop_front());
        end
        if (flush_i) sb.delete();
        if (do_push) sb.push_back(slot_in);
        if (flush_i || do_pop || size == 0) exp_stall = 0;
        else if (!dispatch_i && exp_stall < STALL_MAX) exp_stall++;
        exp_nh = !flush_i && ((do_push && !do_pop && size == 0) || (do_pop && sb.size() >= 1));

        @(posedge clk);
        #1;
        check("count", 64'(count_o), 64'(sb.size()));
        check("new_head", 64'(new_head_o), 64'(exp_nh));
        check("stall_cnt", 64'(stall_cnt_o), 64'(exp_stall));
        if (sb.size() != 0) check("head_data", 64'(head_obs()), 64'(sb[0]));
        else                check("head_masked", 64'(head_obs()), 64'(0));
    endtask

    task automatic step(input logic v, input logic [SLOT_W-1:0] s, input logic d, input logic f);
        enq_valid_i = v;
        slot_in     = s;
        dispatch_i  = d;
        flush_i     = f;
        cycle();
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        reset       = 1'b1;
        enq_valid_i = 1'b0;
        slot_in     = '0;
        dispatch_i  = 1'b0;
        flush_i     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_count", 64'(count_o), 64'(0));
        check("rst_head_valid", 64'(head_valid_o), 64'(0));
        check("rst_enq_ready", 64'(enq_ready_o), 64'(1));
        check("rst_stall", 64'(stall_cnt_o), 64'(0));
        check("rst_new_head", 64'(new_head_o), 64'(0));
        check("rst_head_data", 64'(head_obs()), 64'(0));
        reset = 1'b0;

        // Single push: A has op0 as a register and op1 as an immediate.
        step(1'b1, mk(0, 4'b1000), 1'b0, 1'b0);
        check("a_new_head", 64'(new_head_o), 64'(1));
        check("a_instr", 64'(current_instr_o), 64'(mk(0, 4'b1000) >> 4));
        idle();
        check("a_new_head_drop", 64'(new_head_o), 64'(0));

        // Fill to DEPTH, offer a fifth entry, then drain in order.
        for (int i = 1; i < 4; i++) step(1'b1, mk(i, 4'(i)), 1'b0, 1'b0);
        check("full_ready", 64'(enq_ready_o), 64'(0));
        step(1'b1, mk(9, 4'hF), 1'b0, 1'b0);
        check("full_reject", 64'(count_o), 64'(DEPTH));
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Concurrent push/pop at count 2, going past the pointer wrap.
        step(1'b1, mk(20, 4'b0101), 1'b0, 1'b0);
        step(1'b1, mk(21, 4'b1010), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, mk(30 + i, 4'(i + 3)), 1'b1, 1'b0);
            check("pp_count", 64'(count_o), 64'(2));
        end
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Hold the head well past saturation, then dispatch it.
        step(1'b1, mk(40, 4'b1100), 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) idle();
        check("stall_sat", 64'(stall_cnt_o), 64'(STALL_MAX));
        step(1'b0, '0, 1'b1, 1'b0);
        check("stall_clear", 64'(stall_cnt_o), 64'(0));

        // Flush with a concurrent enqueue at count 3; the enqueue is dropped.
        for (int i = 0; i < 3; i++) step(1'b1, mk(50 + i, 4'b0011), 1'b0, 1'b0);
        step(1'b1, mk(60, 4'b1111), 1'b0, 1'b1);
        check("flush_count", 64'(count_o), 64'(0));
        check("flush_head_valid", 64'(head_valid_o), 64'(0));
        idle();
        step(1'b1, mk(61, 4'b0110), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        idle();
        check("final_empty", 64'(count_o), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
